// File: rtl/nand_page_buffer_mb.sv
// nand_page_buffer_mb: ring of NUM_BANKS page banks between host and NAND controller.
// Define NAND_BUF_ERR_EN to build the sticky ovf/unf/dir error flags and err_clr.
module nand_page_buffer_mb #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 2048,
   parameter int NUM_BANKS = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           dir,
   input  logic                           abort,
   input  logic                           host_we,
   input  logic [DATA_W-1:0]              host_wdata,
   input  logic                           host_re,
   output logic [DATA_W-1:0]              host_rdata,
   output logic                           host_rvalid,
   output logic                           host_wready,
   output logic                           host_rready,
   input  logic                           cntrl_we,
   input  logic [DATA_W-1:0]              cntrl_wdata,
   input  logic                           cntrl_re,
   output logic [DATA_W-1:0]              cntrl_rdata,
   output logic                           cntrl_rvalid,
   output logic                           cntrl_wready,
   output logic                           cntrl_rready,
   output logic                           page_filled,
   output logic                           page_drained,
   output logic [$clog2(NUM_BANKS+1)-1:0] full_banks,
   output logic                           ovf_err,
   output logic                           unf_err,
   output logic                           dir_err,
   input  logic                           err_clr
);
   localparam int AW = $clog2(DEPTH);
   localparam int BW = $clog2(NUM_BANKS);
   localparam int FW = $clog2(NUM_BANKS+1);
   localparam logic [AW-1:0] LAST_A = AW'(DEPTH-1);
   localparam logic [BW-1:0] LAST_B = BW'(NUM_BANKS-1);
   localparam logic [FW-1:0] NB     = FW'(NUM_BANKS);

   logic [DATA_W-1:0] mem [NUM_BANKS][DEPTH];
   logic              dir_q;
   logic [AW-1:0]     wr_addr, rd_addr;
   logic [BW-1:0]     wr_bank, rd_bank;
   logic [FW-1:0]     full_q;

   logic              idle, wready, rready;
   logic              prod_we, cons_re;
   logic [DATA_W-1:0] prod_wd;
   logic              wr_acc, rd_acc, wr_last, rd_last;

   // producer/consumer steering and access acceptance
   always_comb begin
      idle    = (wr_bank == '0) && (wr_addr == '0) &&
                (rd_bank == '0) && (rd_addr == '0) &&
                (full_q == '0);
      wready  = full_q < NB;
      rready  = full_q != '0;
      prod_we = dir_q ? cntrl_we : host_we;
      prod_wd = dir_q ? cntrl_wdata : host_wdata;
      cons_re = dir_q ? host_re : cntrl_re;
      wr_acc  = prod_we && wready && !abort && !rst;
      rd_acc  = cons_re && rready && !abort && !rst;
      wr_last = wr_acc && (wr_addr == LAST_A);
      rd_last = rd_acc && (rd_addr == LAST_A);
   end

   assign host_wready  = !dir_q && wready;
   assign cntrl_wready =  dir_q && wready;
   assign host_rready  =  dir_q && rready;
   assign cntrl_rready = !dir_q && rready;
   assign full_banks   = full_q;

   // page storage, never cleared
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_bank][wr_addr] <= prod_wd;
   end

   // ring pointers, bank occupancy, read data and pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         dir_q        <= 1'b0;
         wr_addr      <= '0;
         rd_addr      <= '0;
         wr_bank      <= '0;
         rd_bank      <= '0;
         full_q       <= '0;
         host_rdata   <= '0;
         cntrl_rdata  <= '0;
         host_rvalid  <= 1'b0;
         cntrl_rvalid <= 1'b0;
         page_filled  <= 1'b0;
         page_drained <= 1'b0;
      end else if (abort) begin
         wr_addr      <= '0;
         rd_addr      <= '0;
         wr_bank      <= '0;
         rd_bank      <= '0;
         full_q       <= '0;
         host_rvalid  <= 1'b0;
         cntrl_rvalid <= 1'b0;
         page_filled  <= 1'b0;
         page_drained <= 1'b0;
      end else begin
         page_filled  <= wr_last;
         page_drained <= rd_last;
         host_rvalid  <= rd_acc && dir_q;
         cntrl_rvalid <= rd_acc && !dir_q;
         if (rd_acc && dir_q) host_rdata <= mem[rd_bank][rd_addr];
         if (rd_acc && !dir_q) cntrl_rdata <= mem[rd_bank][rd_addr];
         if (wr_acc) wr_addr <= wr_addr + 1'b1;
         if (rd_acc) rd_addr <= rd_addr + 1'b1;
         if (wr_last) wr_bank <= (wr_bank == LAST_B) ? '0 : wr_bank + 1'b1;
         if (rd_last) rd_bank <= (rd_bank == LAST_B) ? '0 : rd_bank + 1'b1;
         unique case ({wr_last, rd_last})
            2'b10:   full_q <= full_q + 1'b1;
            2'b01:   full_q <= full_q - 1'b1;
            default: full_q <= full_q;
         endcase
         // direction only changes while nothing is in flight
         if (idle && !wr_acc) dir_q <= dir;
      end
   end

`ifdef NAND_BUF_ERR_EN
   logic ovf_q, unf_q, dir_err_q;
   logic ovf_ev, unf_ev, dir_ev;

   assign ovf_ev = !abort && prod_we && !wready;
   assign unf_ev = !abort && cons_re && !rready;
   assign dir_ev = !abort && !idle && (dir != dir_q);

   // sticky flags; a same-cycle event beats err_clr
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         dir_err_q <= 1'b0;
      end else begin
         ovf_q     <= ovf_ev || (ovf_q && !err_clr);
         unf_q     <= unf_ev || (unf_q && !err_clr);
         dir_err_q <= dir_ev || (dir_err_q && !err_clr);
      end
   end

   assign ovf_err = ovf_q;
   assign unf_err = unf_q;
   assign dir_err = dir_err_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign ovf_err = 1'b0;
   assign unf_err = 1'b0;
   assign dir_err = 1'b0;
`endif

endmodule
